// File: rtl/svi_array_collector_pkg.sv
// Shared types for the SVI array collector.
// Holds the default element count, the index type and the FSM state enum.
package svi_array_collector_pkg;

   localparam int SIZE_DEF = 8;

   typedef logic [$clog2(SIZE_DEF)-1:0] idx_t;

   typedef enum logic {
      IDLE,
      PRESENT
   } state_e;

endpackage

// File: rtl/svi_array_collector_if.sv
// Per-element event bundle: x requests an event, y/z carry its data.
// Modport O drives the bundle, modport C observes it.
interface I;

   logic x;
   logic y;
   logic z;

   modport O (output x, output y, output z);
   modport C (input x, input y, input z);

endinterface

// File: rtl/svi_array_collector_rr_pick.sv
// Round-robin search: first set bit of mask_i at or after ptr_i,
// wrapping from SIZE-1 back to 0.
module svi_rr_pick
   import svi_array_collector_pkg::*;
#(
   parameter int SIZE = SIZE_DEF
) (
   input  logic [SIZE-1:0]         mask_i,
   input  logic [$clog2(SIZE)-1:0] ptr_i,
   output logic                    found_o,
   output logic [$clog2(SIZE)-1:0] idx_o
);

   localparam int IW = $clog2(SIZE);
   localparam logic [IW:0] SZ = (IW + 1)'(SIZE);

   logic [IW:0] s;

   // Scan farthest-first so the nearest hit is written last.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      s       = '0;
      for (int k = SIZE - 1; k >= 0; k--) begin
         s = {1'b0, ptr_i} + (IW + 1)'(k);
         if (s >= SZ) s = s - SZ;
         if (mask_i[s[IW-1:0]]) begin
            found_o = 1'b1;
            idx_o   = s[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/svi_array_collector.sv
// Collects rising-edge events from an array of I bundles and presents them
// one at a time, round-robin. Optional o_par under SVI_COLLECT_PARITY_EN.
module svi_array_collector
   import svi_array_collector_pkg::*;
#(
   parameter int SIZE = SIZE_DEF
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   I.C                             p [SIZE],
   input  logic                    i_ready,
   output logic                    o_valid,
   output logic [$clog2(SIZE)-1:0] o_idx,
   output logic                    o_y,
   output logic                    o_z,
`ifdef SVI_COLLECT_PARITY_EN
   output logic                    o_par,
`endif
   output logic                    o_overflow
);

   localparam int IW = $clog2(SIZE);

   logic [SIZE-1:0] px, py, pz;
   logic [SIZE-1:0] x_q, x_qq, y_q, z_q, arm_q;
   logic [SIZE-1:0] pend_q, pend_d;
   logic [SIZE-1:0] hy_q, hz_q;
   logic [SIZE-1:0] ev, gnt, hld_en;
   logic [IW-1:0]   ptr_q, ptr_d, pidx;
   logic [IW-1:0]   idx_q, idx_d;
   logic            val_q, val_d;
   logic            oy_q, oy_d, oz_q, oz_d;
   logic            ovf_q, ovf_d;
   logic            par_q;
   logic            found, take;
   state_e          state_q, state_d;

   for (genvar i = 0; i < SIZE; i++) begin : g_el
      assign px[i] = p[i].x;
      assign py[i] = p[i].y;
      assign pz[i] = p[i].z;
   end

   // arm_q blocks an event until x has been seen low after reset.
   assign ev = x_q & ~x_qq & arm_q;

   svi_rr_pick #(.SIZE(SIZE)) u_pick (
      .mask_i  (pend_q),
      .ptr_i   (ptr_q),
      .found_o (found),
      .idx_o   (pidx)
   );

   always_comb begin
      state_d = state_q;
      val_d   = val_q;
      idx_d   = idx_q;
      oy_d    = oy_q;
      oz_d    = oz_q;
      take    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (found) take = 1'b1;
         end
         PRESENT: begin
            if (i_ready) begin
               if (found) begin
                  take = 1'b1;
               end else begin
                  state_d = IDLE;
                  val_d   = 1'b0;
               end
            end
         end
         default: ;
      endcase
      if (take) begin
         state_d = PRESENT;
         val_d   = 1'b1;
         idx_d   = pidx;
         oy_d    = hy_q[pidx];
         oz_d    = hz_q[pidx];
      end
   end

   always_comb begin
      gnt   = '0;
      ptr_d = ptr_q;
      if (take) begin
         gnt   = SIZE'(1) << pidx;
         ptr_d = (pidx == IW'(SIZE - 1)) ? '0 : pidx + 1'b1;
      end
   end

   // A grant in the same cycle frees the slot for the new event.
   always_comb begin
      pend_d = (pend_q & ~gnt) | ev;
      hld_en = ev & (~pend_q | gnt);
      ovf_d  = ovf_q | (|(ev & pend_q & ~gnt));
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         x_q     <= '0;
         x_qq    <= '0;
         y_q     <= '0;
         z_q     <= '0;
         arm_q   <= '0;
         pend_q  <= '0;
         hy_q    <= '0;
         hz_q    <= '0;
         ptr_q   <= '0;
         state_q <= IDLE;
         val_q   <= 1'b0;
         idx_q   <= '0;
         oy_q    <= 1'b0;
         oz_q    <= 1'b0;
         ovf_q   <= 1'b0;
         par_q   <= 1'b0;
      end else begin
         x_q     <= px;
         x_qq    <= x_q;
         y_q     <= py;
         z_q     <= pz;
         arm_q   <= arm_q | ~px;
         pend_q  <= pend_d;
         hy_q    <= (hy_q & ~hld_en) | (y_q & hld_en);
         hz_q    <= (hz_q & ~hld_en) | (z_q & hld_en);
         ptr_q   <= ptr_d;
         state_q <= state_d;
         val_q   <= val_d;
         idx_q   <= idx_d;
         oy_q    <= oy_d;
         oz_q    <= oz_d;
         ovf_q   <= ovf_d;
         par_q   <= oy_d ^ oz_d ^ (^idx_d);
      end
   end

   assign o_valid    = val_q;
   assign o_idx      = idx_q;
   assign o_y        = oy_q;
   assign o_z        = oz_q;
   assign o_overflow = ovf_q;

`ifdef SVI_COLLECT_PARITY_EN
   assign o_par = par_q;
`else
   logic unused_par;
   assign unused_par = par_q;
`endif

endmodule

// File: tb/tb_svi_array_collector.sv
// Directed bench for svi_array_collector with SIZE=8.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_svi_array_collector;

   logic       clk = 1'b0;
   logic       rst;
   logic       ready;
   logic [7:0] xs, ys, zs;
   logic       o_valid, o_y, o_z, o_overflow;
   logic [2:0] o_idx;
`ifdef SVI_COLLECT_PARITY_EN
   logic       o_par;
`endif
   int         ncmp = 0;
   int         nerr = 0;

   always #5 clk = ~clk;

   I p_if [8] ();

   for (genvar g = 0; g < 8; g++) begin : g_drv
      assign p_if[g].x = xs[g];
      assign p_if[g].y = ys[g];
      assign p_if[g].z = zs[g];
   end

   svi_array_collector #(.SIZE(8)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .p          (p_if),
      .i_ready    (ready),
      .o_valid    (o_valid),
      .o_idx      (o_idx),
      .o_y        (o_y),
      .o_z        (o_z),
`ifdef SVI_COLLECT_PARITY_EN
      .o_par      (o_par),
`endif
      .o_overflow (o_overflow)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v,
                          input logic [2:0] i, input logic y, input logic z);
      chk({tag, ".valid"}, 32'(o_valid), 32'(v));
      if (v) begin
         chk({tag, ".idx"}, 32'(o_idx), 32'(i));
         chk({tag, ".y"}, 32'(o_y), 32'(y));
         chk({tag, ".z"}, 32'(o_z), 32'(z));
`ifdef SVI_COLLECT_PARITY_EN
         chk({tag, ".par"}, 32'(o_par), 32'(y ^ z ^ (^i)));
`endif
      end
   endtask

   initial begin
      rst = 1'b1; ready = 1'b0;
      xs = '0; ys = '0; zs = '0;
      #1;
      chk("rst.valid", 32'(o_valid), 0);
      chk("rst.idx", 32'(o_idx), 0);
      chk("rst.y", 32'(o_y), 0);
      chk("rst.z", 32'(o_z), 0);
      chk("rst.ovf", 32'(o_overflow), 0);
      step(); step();
      rst = 1'b0;
      step();

      // three simultaneous events from ptr=0
      ready = 1'b1;
      xs = 8'h62; ys = 8'h42; zs = 8'h60;
      step(); xs = '0;
      step(); chk_out("t2.e1", 0, 0, 0, 0);
      step(); chk_out("t2.g1", 1, 3'd1, 1, 0);
      step(); chk_out("t2.g5", 1, 3'd5, 0, 1);
      step(); chk_out("t2.g6", 1, 3'd6, 1, 1);
      step(); chk_out("t2.idle", 0, 0, 0, 0);

      // ptr=7: 7 then wrap to 0
      xs = 8'h81; ys = 8'h80; zs = 8'h01;
      step(); xs = '0;
      step(); chk_out("t6.e1", 0, 0, 0, 0);
      step(); chk_out("t6.g7", 1, 3'd7, 1, 0);
      step(); chk_out("t6.g0", 1, 3'd0, 0, 1);
      step(); chk_out("t6.idle", 0, 0, 0, 0);

      // single pulse on element 3
      xs = 8'h08; ys = 8'h08; zs = 8'h00;
      step(); xs = '0;
      step(); chk_out("t1.e1", 0, 0, 0, 0);
      step(); chk_out("t1.g3", 1, 3'd3, 1, 0);
      step(); chk_out("t1.once", 0, 0, 0, 0);

      // backpressure on element 2
      ready = 1'b0;
      xs = 8'h04; ys = 8'h00; zs = 8'h04;
      step(); xs = '0;
      step();
      step(); chk_out("t3.g2", 1, 3'd2, 0, 1);
      for (int k = 0; k < 4; k++) begin
         step(); chk_out("t3.hold", 1, 3'd2, 0, 1);
      end
      ready = 1'b1;
      step(); chk_out("t3.acc", 0, 0, 0, 0);

      // overflow on element 4 while 0 is stalled
      ready = 1'b0;
      xs = 8'h01; ys = 8'h01; zs = 8'h01;
      step(); xs = '0;
      step();
      step(); chk_out("t4.g0", 1, 3'd0, 1, 1);
      xs = 8'h10; ys = 8'h10; zs = 8'h00;
      step(); xs = '0;
      step(); chk("t4.ovf0", 32'(o_overflow), 0);
      xs = 8'h10; ys = 8'h00; zs = 8'h10;
      step(); xs = '0;
      chk("t4.ovf1", 32'(o_overflow), 0);
      step(); chk("t4.ovf2", 32'(o_overflow), 1);
      chk_out("t4.stall", 1, 3'd0, 1, 1);
      ready = 1'b1;
      step(); chk_out("t4.g4", 1, 3'd4, 1, 0);
      step(); chk_out("t4.idle", 0, 0, 0, 0);
      chk("t4.sticky", 32'(o_overflow), 1);

      // reset mid-presentation, x5 held high across it
      ready = 1'b0;
      xs = 8'h66; ys = 8'hFF; zs = 8'h00;
      step(); xs = 8'h20;
      step();
      step(); chk_out("t5.g5", 1, 3'd5, 1, 0);
      step();
      #1 rst = 1'b1;
      #1;
      chk("t5.rst.valid", 32'(o_valid), 0);
      chk("t5.rst.idx", 32'(o_idx), 0);
      chk("t5.rst.y", 32'(o_y), 0);
      chk("t5.rst.ovf", 32'(o_overflow), 0);
      step(); step();
      rst = 1'b0; ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step(); chk_out("t5.none", 0, 0, 0, 0);
         chk("t5.ovf", 32'(o_overflow), 0);
      end
      xs = '0;
      step(); step();
      xs = 8'h20;
      step(); xs = '0;
      step(); chk_out("t5.e1", 0, 0, 0, 0);
      step(); chk_out("t5.rearm", 1, 3'd5, 1, 0);
      step(); chk_out("t5.idle", 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
